// File: rtl/gun_sense.sv
// Light-gun trigger debounce and two-frame (black/white) hit detection.
// Optional macro GUN_CHEAT_CHECK_EN: light seen during the BLACK frame forces a miss.
module gun_sense #(
    parameter int unsigned DEBOUNCE_CYCLES  = 250000,
    parameter int unsigned LIGHT_MIN_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger_raw,
    input  logic       light_raw,
    input  logic       frame_start,
    output logic       trigger,
    output logic       hit,
    output logic       miss,
    output logic [7:0] hit_count,
    output logic [7:0] shot_count,
    output logic       busy
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLACK,
        BLACK,
        WHITE,
        HOLD
    } state_t;

    state_t      state, state_next;
    logic        trig_s1, trig_s2;
    logic        light_s1, light_s2;
    logic [DB_W-1:0] db_cnt;
    logic        trigger_q;
    logic        shot_start;
    logic [19:0] light_cnt;
    logic        light_lit;
    logic        score_hit;
    logic        light_clr;
    logic        light_inc;
    logic        eval;
`ifdef GUN_CHEAT_CHECK_EN
    logic        black_lit;
    logic        latch_black;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1  <= 1'b0;
            trig_s2  <= 1'b0;
            light_s1 <= 1'b0;
            light_s2 <= 1'b0;
        end else begin
            trig_s1  <= trigger_raw;
            trig_s2  <= trig_s1;
            light_s1 <= light_raw;
            light_s2 <= light_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= '0;
            trigger   <= 1'b0;
            trigger_q <= 1'b0;
        end else begin
            trigger_q <= trigger;
            if (trig_s2 == trigger) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt  <= '0;
                trigger <= ~trigger;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign shot_start = trigger & ~trigger_q;
    assign light_lit  = 32'(light_cnt) >= LIGHT_MIN_CYCLES;
`ifdef GUN_CHEAT_CHECK_EN
    assign score_hit  = light_lit & ~black_lit;
`else
    assign score_hit  = light_lit;
`endif
    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        light_clr  = 1'b0;
        light_inc  = 1'b0;
        eval       = 1'b0;
`ifdef GUN_CHEAT_CHECK_EN
        latch_black = 1'b0;
`endif
        case (state)
            IDLE: begin
                // frame_start is ignored here, even when coincident with shot start
                if (shot_start) begin
                    state_next = WAIT_BLACK;
                    light_clr  = 1'b1;
                end
            end
            WAIT_BLACK: begin
                if (frame_start) state_next = BLACK;
            end
            BLACK: begin
                if (frame_start) begin
`ifdef GUN_CHEAT_CHECK_EN
                    latch_black = 1'b1;
`endif
                    light_clr  = 1'b1;
                    state_next = WHITE;
                end else begin
                    light_inc = light_s2;
                end
            end
            WHITE: begin
                if (frame_start) begin
                    eval       = 1'b1;
                    state_next = HOLD;
                end else begin
                    light_inc = light_s2;
                end
            end
            HOLD: begin
                if (!trigger) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            light_cnt  <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            hit_count  <= '0;
            shot_count <= '0;
        end else begin
            state <= state_next;
            hit   <= eval & score_hit;
            miss  <= eval & ~score_hit;
            if (light_clr) begin
                light_cnt <= '0;
            end else if (light_inc && light_cnt != '1) begin
                light_cnt <= light_cnt + 1'b1;
            end
            if (eval) begin
                if (shot_count != '1) shot_count <= shot_count + 1'b1;
                if (score_hit && hit_count != '1) hit_count <= hit_count + 1'b1;
            end
        end
    end

`ifdef GUN_CHEAT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            black_lit <= 1'b0;
        end else if (latch_black) begin
            black_lit <= light_lit;
        end
    end
`endif

endmodule

// File: tb/tb_gun_sense.sv
// Directed self-checking bench for gun_sense (debounce, scoring, thresholds, reset, saturation).
module tb_gun_sense;

    logic       clk = 1'b0;
    logic       rst, trigger_raw, light_raw, frame_start;
    logic       trigger, hit, miss, busy;
    logic [7:0] hit_count, shot_count;
    logic       s_trigger, s_hit, s_miss, s_busy;
    logic [7:0] s_hit_count, s_shot_count;

    int compared = 0;
    int mismatched = 0;
    int hit_pulses = 0;
    int miss_pulses = 0;
    int both_seen = 0;

    always #5 clk = ~clk;

    gun_sense #(.DEBOUNCE_CYCLES(4), .LIGHT_MIN_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .trigger_raw(trigger_raw), .light_raw(light_raw),
        .frame_start(frame_start), .trigger(trigger), .hit(hit), .miss(miss),
        .hit_count(hit_count), .shot_count(shot_count), .busy(busy)
    );

    // Short light threshold so 300 shots fit in a small cycle budget.
    gun_sense #(.DEBOUNCE_CYCLES(4), .LIGHT_MIN_CYCLES(2)) dut_sat (
        .clk(clk), .rst(rst), .trigger_raw(trigger_raw), .light_raw(light_raw),
        .frame_start(frame_start), .trigger(s_trigger), .hit(s_hit), .miss(s_miss),
        .hit_count(s_hit_count), .shot_count(s_shot_count), .busy(s_busy)
    );

    always @(negedge clk) begin
        if (hit) hit_pulses++;
        if (miss) miss_pulses++;
        if (hit && miss) both_seen++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; trigger_raw = 1'b0; light_raw = 1'b0; frame_start = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic light_for(input int n);
        if (n > 0) begin
            light_raw = 1'b1;
            tick(n);
            light_raw = 1'b0;
            tick(3);
        end
    endtask

    task automatic pull();
        int k;
        trigger_raw = 1'b1;
        for (k = 0; k < 40 && trigger !== 1'b1; k++) tick(1);
        if (trigger !== 1'b1) begin
            mismatched++;
            $display("FAIL pull_timeout: trigger=%b want 1 within 40 cycles", trigger);
        end
    endtask

    task automatic release_trig();
        int k;
        trigger_raw = 1'b0;
        for (k = 0; k < 40 && trigger !== 1'b0; k++) tick(1);
        if (trigger !== 1'b0) begin
            mismatched++;
            $display("FAIL release_timeout: trigger=%b want 0 within 40 cycles", trigger);
        end
        tick(1);
    endtask

    // Called right after pull(); ends just after the evaluating frame_start edge.
    task automatic shot_frames(input int black_n, input int white_n);
        tick(1);
        pulse_frame();
        light_for(black_n);
        pulse_frame();
        light_for(white_n);
        pulse_frame();
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (trigger !== 1'b0) begin mismatched++; $display("FAIL rst_trigger: got %b want 0", trigger); end
        compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL rst_hit: got %b want 0", hit); end
        compared++; if (miss !== 1'b0) begin mismatched++; $display("FAIL rst_miss: got %b want 0", miss); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
        compared++; if (hit_count !== 8'd0) begin mismatched++; $display("FAIL rst_hit_count: got %0d want 0", hit_count); end
        compared++; if (shot_count !== 8'd0) begin mismatched++; $display("FAIL rst_shot_count: got %0d want 0", shot_count); end
        pulse_frame();
        tick(1);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_frame_busy: got %b want 0", busy); end
    endtask

    task automatic test_debounce();
        int lat, rises;
        logic prev;
        do_reset();
        trigger_raw = 1'b1; tick(2);
        trigger_raw = 1'b0; tick(2);
        trigger_raw = 1'b1;
        lat = 0;
        while (trigger !== 1'b1 && lat < 30) begin
            tick(1);
            lat++;
        end
        compared++; if (lat !== 6) begin mismatched++; $display("FAIL debounce_latency: got %0d want 6", lat); end
        rises = 1;
        prev = trigger;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (trigger === 1'b1 && prev !== 1'b1) rises++;
            prev = trigger;
        end
        compared++; if (rises !== 1) begin mismatched++; $display("FAIL debounce_rises: got %0d want 1", rises); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL debounce_busy: got %b want 1", busy); end
    endtask

    task automatic test_hit();
        do_reset();
        pull();
        shot_frames(0, 1500);
        compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL hit_pulse: got %b want 1", hit); end
        compared++; if (miss !== 1'b0) begin mismatched++; $display("FAIL hit_no_miss: got %b want 0", miss); end
        tick(1);
        compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL hit_one_cycle: got %b want 0", hit); end
        compared++; if (hit_count !== 8'd1) begin mismatched++; $display("FAIL hit_hit_count: got %0d want 1", hit_count); end
        compared++; if (shot_count !== 8'd1) begin mismatched++; $display("FAIL hit_shot_count: got %0d want 1", shot_count); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL hold_busy: got %b want 1", busy); end
        release_trig();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL release_idle: got %b want 0", busy); end
    endtask

    task automatic test_threshold();
        do_reset();
        pull();
        shot_frames(0, 999);
        compared++; if (miss !== 1'b1) begin mismatched++; $display("FAIL thr999_miss: got %b want 1", miss); end
        compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL thr999_hit: got %b want 0", hit); end
        tick(1);
        compared++; if (hit_count !== 8'd0) begin mismatched++; $display("FAIL thr999_hit_count: got %0d want 0", hit_count); end
        compared++; if (shot_count !== 8'd1) begin mismatched++; $display("FAIL thr999_shot_count: got %0d want 1", shot_count); end
        release_trig();
        pull();
        shot_frames(0, 1000);
        compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL thr1000_hit: got %b want 1", hit); end
        tick(1);
        compared++; if (hit_count !== 8'd1) begin mismatched++; $display("FAIL thr1000_hit_count: got %0d want 1", hit_count); end
        compared++; if (shot_count !== 8'd2) begin mismatched++; $display("FAIL thr1000_shot_count: got %0d want 2", shot_count); end
        release_trig();
    endtask

    task automatic test_cheat();
        logic exp_hit;
`ifdef GUN_CHEAT_CHECK_EN
        exp_hit = 1'b0;
`else
        exp_hit = 1'b1;
`endif
        do_reset();
        pull();
        shot_frames(1200, 1200);
        compared++; if (hit !== exp_hit) begin mismatched++; $display("FAIL cheat_hit: got %b want %b", hit, exp_hit); end
        compared++; if (miss !== ~exp_hit) begin mismatched++; $display("FAIL cheat_miss: got %b want %b", miss, ~exp_hit); end
        release_trig();
    endtask

    task automatic test_coincident();
        do_reset();
        pull();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL coinc_busy: got %b want 1", busy); end
        pulse_frame();
        pulse_frame();
        compared++; if ((hit | miss) !== 1'b0) begin mismatched++; $display("FAIL coinc_early_eval: got %b want 0", hit | miss); end
        light_for(1500);
        pulse_frame();
        compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL coinc_hit: got %b want 1", hit); end
        release_trig();
    endtask

    task automatic test_reset_mid();
        int p0;
        do_reset();
        pull();
        tick(1);
        pulse_frame();
        pulse_frame();
        light_raw = 1'b1;
        tick(500);
        p0 = hit_pulses + miss_pulses;
        rst = 1'b1; trigger_raw = 1'b0;
        tick(1);
        rst = 1'b0; light_raw = 1'b0;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        compared++; if (shot_count !== 8'd0) begin mismatched++; $display("FAIL rstmid_shot_count: got %0d want 0", shot_count); end
        compared++; if (hit_count !== 8'd0) begin mismatched++; $display("FAIL rstmid_hit_count: got %0d want 0", hit_count); end
        pulse_frame();
        tick(3);
        compared++; if (hit_pulses + miss_pulses !== p0) begin mismatched++; $display("FAIL rstmid_pulses: got %0d want %0d", hit_pulses + miss_pulses, p0); end
    endtask

    task automatic test_back_to_back();
        int p0;
        do_reset();
        pull();
        shot_frames(0, 1500);
        compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL b2b_first_hit: got %b want 1", hit); end
        tick(5);
        p0 = hit_pulses + miss_pulses;
        pulse_frame();
        tick(2);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_hold_busy: got %b want 1", busy); end
        compared++; if (hit_pulses + miss_pulses !== p0) begin mismatched++; $display("FAIL b2b_hold_frame: got %0d want %0d", hit_pulses + miss_pulses, p0); end
        release_trig();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_released: got %b want 0", busy); end
        pull();
        tick(1);
        pulse_frame();
        release_trig();
        pull();
        tick(1);
        pulse_frame();
        light_for(1500);
        p0 = hit_pulses + miss_pulses;
        pulse_frame();
        compared++; if (hit !== 1'b1) begin mismatched++; $display("FAIL b2b_second_hit: got %b want 1", hit); end
        tick(1);
        release_trig();
        for (int i = 0; i < 3; i++) begin
            pulse_frame();
            tick(2);
        end
        compared++; if (hit_pulses + miss_pulses !== p0 + 1) begin mismatched++; $display("FAIL b2b_eval_count: got %0d want %0d", hit_pulses + miss_pulses, p0 + 1); end
        compared++; if (shot_count !== 8'd2) begin mismatched++; $display("FAIL b2b_shot_count: got %0d want 2", shot_count); end
        compared++; if (hit_count !== 8'd2) begin mismatched++; $display("FAIL b2b_hit_count: got %0d want 2", hit_count); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_final_idle: got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            pull();
            shot_frames(0, 4);
            tick(1);
            release_trig();
        end
        compared++; if (s_hit_count !== 8'd255) begin mismatched++; $display("FAIL sat_hit_count: got %0d want 255", s_hit_count); end
        compared++; if (s_shot_count !== 8'd255) begin mismatched++; $display("FAIL sat_shot_count: got %0d want 255", s_shot_count); end
        compared++; if (shot_count !== 8'd255) begin mismatched++; $display("FAIL sat_main_shot_count: got %0d want 255", shot_count); end
        compared++; if (hit_count !== 8'd0) begin mismatched++; $display("FAIL sat_main_hit_count: got %0d want 0", hit_count); end
    endtask

    initial begin
        rst = 1'b1; trigger_raw = 1'b0; light_raw = 1'b0; frame_start = 1'b0;
        test_reset();
        test_debounce();
        test_hit();
        test_threshold();
        test_cheat();
        test_coincident();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        compared++; if (both_seen !== 0) begin mismatched++; $display("FAIL hit_and_miss_together: got %0d want 0", both_seen); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gun_sense.md
GUN_SENSE -- requirements
Module: gun_sense

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, stable-input cycles required before the debounced trigger changes (10 ms at 25 MHz).
REQ-002 Parameter LIGHT_MIN_CYCLES, default 1000, minimum lit-sensor cycles within one frame that count as "light seen".
REQ-003 Port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port trigger_raw  input  1  asynchronous gun trigger switch, high = pulled.
REQ-006 Port light_raw  input  1  asynchronous photodiode, high = light detected.
REQ-007 Port frame_start  input  1  one-cycle pulse in clk domain at the start of each video frame.
REQ-008 Port trigger  output  1  debounced trigger level, consumed by the pattern generator.
REQ-009 Port hit  output  1  one-cycle pulse, shot scored as hit.
REQ-010 Port miss  output  1  one-cycle pulse, shot scored as miss.
REQ-011 Port hit_count  output  8  hits since reset, saturating.
REQ-012 Port shot_count  output  8  shots since reset, saturating.
REQ-013 Port busy  output  1  high in every state except IDLE.

Function
REQ-014 trigger_raw and light_raw each pass through a 2-flop synchronizer before any use.
REQ-015 Debounce: counter clears whenever the synchronized trigger equals trigger; otherwise increments; trigger toggles and counter clears when counter reaches DEBOUNCE_CYCLES-1.
REQ-016 Shot start = debounced trigger rising edge (trigger high, previous-cycle trigger low).
REQ-017 FSM states: IDLE, WAIT_BLACK, BLACK, WHITE, HOLD.
REQ-018 IDLE -> WAIT_BLACK on shot start; shot start seen outside IDLE is ignored.
REQ-019 WAIT_BLACK -> BLACK on frame_start; light counter cleared on entry.
REQ-020 BLACK: light counter increments each cycle with synchronized light high, saturating at 2^20-1; on frame_start latch black_lit = (count >= LIGHT_MIN_CYCLES), clear counter, -> WHITE.
REQ-021 WHITE: same counting; on frame_start -> HOLD and evaluate shot: hit if count >= LIGHT_MIN_CYCLES and black_lit low, else miss.
REQ-022 hit or miss pulses for exactly one cycle, the cycle after the evaluating frame_start; never both.
REQ-023 shot_count increments with each hit or miss pulse, hit_count with each hit pulse; both hold at 255.
REQ-024 HOLD -> IDLE in the first cycle trigger is low, including the cycle immediately after entry.
REQ-025 Shot start coincident with frame_start in IDLE: enter WAIT_BLACK; that frame_start does not advance the FSM further.
REQ-026 frame_start in IDLE or HOLD has no effect.
REQ-027 Light count equal to LIGHT_MIN_CYCLES qualifies as lit (inclusive threshold).

Reset
REQ-028 While rst is high at a clk edge: FSM -> IDLE; trigger, hit, miss, busy = 0; hit_count, shot_count = 0; debounce counter, light counter, black_lit, synchronizers = 0.
REQ-029 Reset mid-shot aborts it without any hit/miss pulse or counter update.
REQ-030 First shot after reset requires a full debounce interval of stable trigger high.

Configuration
REQ-031 Macro GUN_CHEAT_CHECK_EN defined: black_lit from the BLACK frame disqualifies the shot (forces miss).
REQ-032 Macro GUN_CHEAT_CHECK_EN undefined: black_lit is not computed, BLACK frame light is ignored, hit depends only on WHITE count; FSM sequence unchanged.

Verification
REQ-033 DEBOUNCE_CYCLES=4; trigger_raw bounces 1-0-1 with 2-cycle gaps, then held high -> trigger rises exactly 2+4 cycles after the last edge, one shot start only.
REQ-034 Shot start; light high 0 cycles in BLACK, 1500 cycles in WHITE (LIGHT_MIN_CYCLES=1000) -> hit pulse 1 cycle after the third frame_start, hit_count=1, shot_count=1.
REQ-035 Same as REQ-034 but WHITE light exactly 999 cycles -> miss pulse, hit_count=0, shot_count=1; with 1000 cycles -> hit.
REQ-036 Light high throughout BLACK and WHITE -> miss with GUN_CHEAT_CHECK_EN defined, hit without.
REQ-037 rst asserted during WHITE -> no hit/miss pulse, counts 0, busy=0 next cycle; 300 qualifying shots -> hit_count and shot_count both 255.
REQ-038 Trigger held high through HOLD and re-pulled after release during a 2nd shot -> exactly one evaluation per full release/pull cycle; pull in BLACK ignored.
